// File: rtl/conv_mem_responder_pkg.sv
// Shared definitions for the convolution memory responder and the CONV engine:
// data/address widths, FSM state encoding, and the csel -> layer bank map.
package conv_mem_responder_pkg;

    localparam int DATA_WIDTH = 20;
    localparam int ADDR_WIDTH = 12;

    // Control FSM states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READY     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_RUN       = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    // csel codes; 0, 6 and 7 select nothing
    localparam logic [2:0] CSEL_L0_K0 = 3'd1;
    localparam logic [2:0] CSEL_L0_K1 = 3'd2;
    localparam logic [2:0] CSEL_L1_K0 = 3'd3;
    localparam logic [2:0] CSEL_L1_K1 = 3'd4;
    localparam logic [2:0] CSEL_L2    = 3'd5;

    // Bank depths per layer
    localparam int L0_DEPTH = 4096;
    localparam int L1_DEPTH = 1024;
    localparam int L2_DEPTH = 2048;

    // Physical layer banks; bank index i is selected by csel code i+1
    localparam int NUM_BANKS  = 5;
    localparam int BANK_IDX_W = 3;

    // Depth of physical bank number idx (0 when idx names no bank)
    function automatic int bank_depth(input int idx);
        int d;
        case (idx)
            0, 1:    d = L0_DEPTH;
            2, 3:    d = L1_DEPTH;
            4:       d = L2_DEPTH;
            default: d = 0;
        endcase
        return d;
    endfunction

    // Depth of the bank addressed by a csel code (0 for invalid codes)
    function automatic int csel_depth(input logic [2:0] csel);
        int d;
        case (csel)
            CSEL_L0_K0, CSEL_L0_K1: d = L0_DEPTH;
            CSEL_L1_K0, CSEL_L1_K1: d = L1_DEPTH;
            CSEL_L2:                d = L2_DEPTH;
            default:                d = 0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/conv_bank_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read and a write to the same word in the same cycle returns the old word.
// Only the read register is cleared by srst; the array contents survive reset.
module conv_bank_ram #(
    parameter int DEPTH = 4096,
    parameter int WIDTH = 20,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_reg;

    // Write port: array is never reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: registered, holds its value while re is low
    always_ff @(posedge clk) begin
        if (srst) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/conv_mem_responder.sv
// Memory-side responder for a convolution engine: holds the preloaded input
// image, the five layer banks, and the run-control handshake
// (start -> ready pulse -> wait for busy -> run -> done pulse).
module conv_mem_responder #(
    parameter int DATA_WIDTH = conv_mem_responder_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = conv_mem_responder_pkg::ADDR_WIDTH,
    parameter int TIMEOUT    = 4096,
    parameter int RUN_LIMIT  = 1 << 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  ready,
    input  logic                  busy,
    input  logic [ADDR_WIDTH-1:0] iaddr,
    output logic [DATA_WIDTH-1:0] idata,
    input  logic                  cwr,
    input  logic [ADDR_WIDTH-1:0] caddr_wr,
    input  logic [DATA_WIDTH-1:0] cdata_wr,
    input  logic                  crd,
    input  logic [ADDR_WIDTH-1:0] caddr_rd,
    output logic [DATA_WIDTH-1:0] cdata_rd,
    input  logic [2:0]            csel,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           wr_count
);

    import conv_mem_responder_pkg::*;

    localparam int IMG_DEPTH = 1 << ADDR_WIDTH;
    // One shared counter times both WAIT_BUSY and RUN
    localparam int LIMIT_MAX = (RUN_LIMIT > TIMEOUT) ? RUN_LIMIT : TIMEOUT;
    localparam int CNT_W     = $clog2(LIMIT_MAX) + 1;

    state_t                 state_reg;
    logic [CNT_W-1:0]       cycle_cnt_reg;
    logic                   ready_reg;
    logic                   done_reg;
    logic                   err_reg;
    logic [15:0]            wr_count_reg;
    logic                   rd_hit_reg;
    logic [BANK_IDX_W-1:0]  rd_idx_reg;

    logic                   srst;
    logic                   wait_expired;
    logic                   run_expired;
    logic                   img_we;
    logic                   load_bad;
    int                     sel_depth;
    logic                   sel_valid;
    logic [BANK_IDX_W-1:0]  sel_idx;
    logic                   wr_in_range;
    logic                   rd_in_range;
    logic                   wr_ok;
    logic                   wr_bad;
    logic                   rd_ok;
    logic                   rd_bad;
    logic [DATA_WIDTH-1:0]  bank_q [NUM_BANKS];
    logic [DATA_WIDTH-1:0]  cdata_rd_next;

    // RAM read registers use an active-high clear
    assign srst = ~reset;

    // Bounded-wait expiry: the last permitted cycle of WAIT_BUSY / RUN
    assign wait_expired = (state_reg == ST_WAIT_BUSY) && !busy &&
                          (cycle_cnt_reg == CNT_W'(TIMEOUT - 1));
    assign run_expired  = (state_reg == ST_RUN) && busy &&
                          (cycle_cnt_reg == CNT_W'(RUN_LIMIT - 1));

    // Image preload is only legal while idle
    assign img_we   = load_en && (state_reg == ST_IDLE);
    assign load_bad = load_en && (state_reg != ST_IDLE);

    // Decode csel and address legality for the layer write and read ports
    always_comb begin
        sel_depth   = csel_depth(csel);
        sel_valid   = (sel_depth != 0);
        sel_idx     = csel - 3'd1;
        wr_in_range = (32'(caddr_wr) < 32'(sel_depth));
        rd_in_range = (32'(caddr_rd) < 32'(sel_depth));
        wr_ok       = cwr && (state_reg == ST_RUN) && sel_valid && wr_in_range;
        wr_bad      = cwr && !wr_ok;
        rd_ok       = crd && sel_valid && rd_in_range;
        rd_bad      = crd && !rd_ok;
    end

    // Run-control FSM with registered ready/done pulses
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            cycle_cnt_reg <= '0;
            ready_reg     <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            ready_reg <= 1'b0;
            done_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= ST_READY;
                        ready_reg <= 1'b1;
                    end
                end
                ST_READY: begin
                    state_reg     <= ST_WAIT_BUSY;
                    cycle_cnt_reg <= '0;
                end
                ST_WAIT_BUSY: begin
                    if (busy) begin
                        state_reg     <= ST_RUN;
                        cycle_cnt_reg <= '0;
                    end else if (wait_expired) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!busy || run_expired) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky protocol error: any illegal access or an expired wait
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_reg <= 1'b0;
        end else if (load_bad || wr_bad || rd_bad || wait_expired || run_expired) begin
            err_reg <= 1'b1;
        end
    end

    // Accepted layer writes in the current run, saturating
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_count_reg <= '0;
        end else if ((state_reg == ST_IDLE) && start) begin
            wr_count_reg <= '0;
        end else if (wr_ok && (wr_count_reg != 16'hFFFF)) begin
            wr_count_reg <= wr_count_reg + 16'd1;
        end
    end

    // Input image store, read every cycle
    conv_bank_ram #(
        .DEPTH (IMG_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_image (
        .clk   (clk),
        .srst  (srst),
        .we    (img_we),
        .waddr (load_addr),
        .wdata (load_data),
        .re    (1'b1),
        .raddr (iaddr),
        .rdata (idata)
    );

    // One RAM per layer bank, sized from the shared bank map
    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            localparam int DEPTH = bank_depth(gi);
            localparam int BAW   = $clog2(DEPTH);
            logic bank_we;
            logic bank_re;

            assign bank_we = wr_ok && (sel_idx == BANK_IDX_W'(gi));
            assign bank_re = rd_ok && (sel_idx == BANK_IDX_W'(gi));

            conv_bank_ram #(
                .DEPTH (DEPTH),
                .WIDTH (DATA_WIDTH)
            ) u_bank (
                .clk   (clk),
                .srst  (srst),
                .we    (bank_we),
                .waddr (caddr_wr[BAW-1:0]),
                .wdata (cdata_wr),
                .re    (bank_re),
                .raddr (caddr_rd[BAW-1:0]),
                .rdata (bank_q[gi])
            );
        end
    endgenerate

    // Remember which bank the last read went to; an illegal read yields zero
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_hit_reg <= 1'b0;
            rd_idx_reg <= '0;
        end else if (crd) begin
            rd_hit_reg <= rd_ok;
            rd_idx_reg <= sel_idx;
        end
    end

    // Steer the selected bank's read register onto cdata_rd
    always_comb begin
        cdata_rd_next = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (rd_hit_reg && (rd_idx_reg == BANK_IDX_W'(i))) begin
                cdata_rd_next = bank_q[i];
            end
        end
    end

    assign cdata_rd = cdata_rd_next;
    assign ready    = ready_reg;
    assign done     = done_reg;
    assign err      = err_reg;
    assign wr_count = wr_count_reg;

endmodule

// File: tb/tb_conv_mem_responder.sv
`timescale 1ns/1ps
module tb_conv_mem_responder;

    localparam int DW = 20;
    localparam int AW = 12;
    localparam int TO = 16;
    localparam int RL = 256;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;
    logic          ready;
    logic          busy = 1'b0;
    logic [AW-1:0] iaddr = '0;
    logic [DW-1:0] idata;
    logic          cwr = 1'b0;
    logic [AW-1:0] caddr_wr = '0;
    logic [DW-1:0] cdata_wr = '0;
    logic          crd = 1'b0;
    logic [AW-1:0] caddr_rd = '0;
    logic [DW-1:0] cdata_rd;
    logic [2:0]    csel = '0;
    logic          done;
    logic          err;
    logic [15:0]   wr_count;

    int checks = 0;
    int errors = 0;

    // Reference contents: image by address, layer banks by csel*4096+addr
    logic [DW-1:0] img_model [int];
    logic [DW-1:0] bank_model [int];

    conv_mem_responder #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TO),
        .RUN_LIMIT  (RL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .ready     (ready),
        .busy      (busy),
        .iaddr     (iaddr),
        .idata     (idata),
        .cwr       (cwr),
        .caddr_wr  (caddr_wr),
        .cdata_wr  (cdata_wr),
        .crd       (crd),
        .caddr_rd  (caddr_rd),
        .cdata_rd  (cdata_rd),
        .csel      (csel),
        .done      (done),
        .err       (err),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    // IDLE -> READY -> WAIT_BUSY -> RUN with busy already high
    task automatic start_run();
        busy  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
    endtask

    // RUN -> DONE -> IDLE
    task automatic end_run();
        busy = 1'b0;
        tick();
        tick();
    endtask

    task automatic layer_read(input logic [2:0] c, input int a);
        csel = c;
        caddr_rd = AW'(a);
        crd = 1'b1;
        tick();
        crd = 1'b0;
    endtask

    task automatic layer_write(input logic [2:0] c, input int a, input logic [DW-1:0] d);
        csel = c;
        caddr_wr = AW'(a);
        cdata_wr = d;
        cwr = 1'b1;
        tick();
        cwr = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({ready, done, err, wr_count, idata, cdata_rd} !== 59'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%0b done=%0b err=%0b wr_count=%0d idata=%h cdata_rd=%h, want all 0",
                     ready, done, err, wr_count, idata, cdata_rd);
        end
    endtask

    task automatic test_preload_ready();
        load_en = 1'b1;
        load_addr = 12'd5;
        load_data = 20'h0ABCD;
        tick();
        img_model[5] = 20'h0ABCD;
        for (int i = 0; i < 8; i++) begin
            int a;
            logic [DW-1:0] d;
            a = $urandom_range(4095, 6);
            d = DW'($urandom);
            load_addr = AW'(a);
            load_data = d;
            tick();
            img_model[a] = d;
        end
        load_en = 1'b0;
        busy = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_first_cycle: got %0b want 1", ready);
        end
        iaddr = 12'd5;
        tick();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_one_cycle: got %0b want 0", ready);
        end
        checks++;
        if (idata !== 20'h0ABCD) begin
            errors++;
            $display("FAIL idata_addr5: got %h want 0abcd", idata);
        end
        tick();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_stays_low: got %0b want 0", ready);
        end
        busy = 1'b1;
        tick();
        foreach (img_model[k]) begin
            iaddr = AW'(k);
            tick();
            checks++;
            if (idata !== img_model[k]) begin
                errors++;
                $display("FAIL idata_preload addr %0d: got %h want %h", k, idata, img_model[k]);
            end
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clean_start: got %0b want 0", err);
        end
    endtask

    task automatic test_layer_rw();
        start = 1'b1;
        layer_write(3'd1, 100, 20'h12345);
        start = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored_in_run: ready got %0b want 0", ready);
        end
        layer_read(3'd1, 100);
        checks++;
        if (cdata_rd !== 20'h12345) begin
            errors++;
            $display("FAIL l0_readback: got %h want 12345", cdata_rd);
        end
        checks++;
        if (wr_count !== 16'd1) begin
            errors++;
            $display("FAIL wr_count_one: got %0d want 1", wr_count);
        end
        layer_write(3'd3, 0, 20'h55555);
        layer_write(3'd3, 10, 20'h00003);
        csel = 3'd3;
        caddr_wr = 12'd10;
        cdata_wr = 20'h00007;
        caddr_rd = 12'd10;
        cwr = 1'b1;
        crd = 1'b1;
        tick();
        cwr = 1'b0;
        crd = 1'b0;
        checks++;
        if (cdata_rd !== 20'h00003) begin
            errors++;
            $display("FAIL read_before_write: got %h want 00003", cdata_rd);
        end
        tick();
        checks++;
        if (cdata_rd !== 20'h00003) begin
            errors++;
            $display("FAIL cdata_rd_hold: got %h want 00003", cdata_rd);
        end
        layer_read(3'd3, 10);
        checks++;
        if (cdata_rd !== 20'h00007) begin
            errors++;
            $display("FAIL new_data_after_rbw: got %h want 00007", cdata_rd);
        end
        checks++;
        if (wr_count !== 16'd4 || err !== 1'b0) begin
            errors++;
            $display("FAIL wr_count_four: got wr_count=%0d err=%0b want 4 and 0", wr_count, err);
        end
    endtask

    task automatic test_bad_writes();
        layer_write(3'd3, 1024, 20'h0DEAD);
        layer_write(3'd6, 7, 20'h0BEEF);
        checks++;
        if (wr_count !== 16'd4) begin
            errors++;
            $display("FAIL bad_write_count: got %0d want 4", wr_count);
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL bad_write_err: got %0b want 1", err);
        end
        layer_read(3'd3, 0);
        checks++;
        if (cdata_rd !== 20'h55555) begin
            errors++;
            $display("FAIL no_wrap_write: got %h want 55555", cdata_rd);
        end
        layer_read(3'd3, 1024);
        checks++;
        if (cdata_rd !== 20'h0) begin
            errors++;
            $display("FAIL bad_read_zero: got %h want 0", cdata_rd);
        end
        busy = 1'b0;
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse: got %0b want 1", done);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle: got %0b want 0", done);
        end
    endtask

    task automatic test_reset_mid_run();
        start_run();
        layer_write(3'd5, 2000, 20'h5A5A5);
        iaddr = 12'd5;
        layer_read(3'd1, 100);
        checks++;
        if (cdata_rd !== 20'h12345 || wr_count !== 16'd1) begin
            errors++;
            $display("FAIL pre_reset_state: got cdata_rd=%h wr_count=%0d want 12345 and 1", cdata_rd, wr_count);
        end
        apply_reset();
        checks++;
        if ({ready, done, err, wr_count, idata, cdata_rd} !== 59'd0) begin
            errors++;
            $display("FAIL mid_run_reset: got ready=%0b done=%0b err=%0b wr_count=%0d idata=%h cdata_rd=%h, want all 0",
                     ready, done, err, wr_count, idata, cdata_rd);
        end
        start_run();
        layer_read(3'd1, 100);
        checks++;
        if (cdata_rd !== 20'h12345) begin
            errors++;
            $display("FAIL persist_l0: got %h want 12345", cdata_rd);
        end
        layer_read(3'd3, 10);
        checks++;
        if (cdata_rd !== 20'h00007) begin
            errors++;
            $display("FAIL persist_l1: got %h want 00007", cdata_rd);
        end
        layer_read(3'd5, 2000);
        checks++;
        if (cdata_rd !== 20'h5A5A5) begin
            errors++;
            $display("FAIL persist_l2: got %h want 5a5a5", cdata_rd);
        end
        checks++;
        if (idata !== 20'h0ABCD) begin
            errors++;
            $display("FAIL persist_image: got %h want 0abcd", idata);
        end
        end_run();
    endtask

    task automatic test_load_outside_idle();
        apply_reset();
        busy = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        load_en = 1'b1;
        load_addr = 12'd5;
        load_data = 20'h11111;
        tick();
        load_en = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_load_outside_idle: got %0b want 1", err);
        end
        busy = 1'b1;
        iaddr = 12'd5;
        tick();
        tick();
        checks++;
        if (idata !== img_model[5]) begin
            errors++;
            $display("FAIL image_not_overwritten: got %h want %h", idata, img_model[5]);
        end
        end_run();
    endtask

    task automatic test_timeout();
        int k;
        apply_reset();
        busy = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < TO + 10) begin
            tick();
            k++;
        end
        checks++;
        if (k != TO + 1) begin
            errors++;
            $display("FAIL timeout_latency: done after %0d cycles, want %0d", k, TO + 1);
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_err: got %0b want 1", err);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_done_width: got %0b want 0", done);
        end
    endtask

    task automatic test_run_limit();
        int k;
        apply_reset();
        start_run();
        k = 0;
        while (done !== 1'b1 && k < RL + 10) begin
            tick();
            k++;
        end
        checks++;
        if (k != RL) begin
            errors++;
            $display("FAIL run_limit_latency: done after %0d cycles, want %0d", k, RL);
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL run_limit_err: got %0b want 1", err);
        end
        busy = 1'b0;
        tick();
    endtask

    task automatic pick_valid(output logic [2:0] c, output int a);
        c = 3'($urandom_range(5, 1));
        case (c)
            3'd1:    a = $urandom_range(2047, 0);
            3'd2:    a = $urandom_range(4095, 2048);
            3'd3:    a = $urandom_range(511, 0);
            3'd4:    a = $urandom_range(1023, 512);
            default: a = $urandom_range(2047, 0);
        endcase
    endtask

    task automatic pick_invalid(output logic [2:0] c, output int a);
        int r;
        if ($urandom_range(1, 0) == 1) begin
            r = $urandom_range(2, 0);
            c = (r == 0) ? 3'd0 : (r == 1) ? 3'd6 : 3'd7;
            a = $urandom_range(4095, 0);
        end else begin
            c = 3'($urandom_range(5, 3));
            a = (c == 3'd5) ? $urandom_range(4095, 2048) : $urandom_range(4095, 1024);
        end
    endtask

    task automatic test_random();
        int wr_keys[$];
        int img_keys[$];
        int exp_wr;
        bit exp_err;
        logic [DW-1:0] exp_rd;
        apply_reset();
        exp_wr = 0;
        exp_err = 1'b0;
        exp_rd = '0;
        load_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            int a;
            logic [DW-1:0] d;
            a = $urandom_range(4095, 0);
            d = DW'($urandom);
            load_addr = AW'(a);
            load_data = d;
            tick();
            img_model[a] = d;
        end
        load_en = 1'b0;
        foreach (img_model[k]) img_keys.push_back(k);
        start_run();
        for (int n = 0; n < 150; n++) begin
            int kind;
            int a;
            int key;
            int ia;
            logic [2:0] c;
            logic [DW-1:0] d;
            logic [DW-1:0] exp_id;
            bit wr;
            bit rd;
            bit ok;
            kind = $urandom_range(5, 0);
            d = DW'($urandom);
            wr = 1'b0;
            rd = 1'b0;
            ok = 1'b1;
            if ((kind == 2 || kind == 3) && wr_keys.size() > 0) begin
                key = wr_keys[$urandom_range(wr_keys.size() - 1, 0)];
                c = 3'(key / 4096);
                a = key % 4096;
                rd = 1'b1;
                wr = (kind == 3);
            end else if (kind == 4 || kind == 5) begin
                pick_invalid(c, a);
                ok = 1'b0;
                wr = (kind == 4);
                rd = (kind == 5);
            end else begin
                pick_valid(c, a);
                wr = 1'b1;
            end
            key = int'(c) * 4096 + a;
            if (rd) begin
                if (ok) exp_rd = bank_model[key];
                else begin
                    exp_rd = '0;
                    exp_err = 1'b1;
                end
            end
            if (wr) begin
                if (ok) begin
                    if (!bank_model.exists(key)) wr_keys.push_back(key);
                    bank_model[key] = d;
                    if (exp_wr < 65535) exp_wr++;
                end else begin
                    exp_err = 1'b1;
                end
            end
            ia = img_keys[$urandom_range(img_keys.size() - 1, 0)];
            exp_id = img_model[ia];
            csel = c;
            caddr_wr = AW'(a);
            caddr_rd = AW'(a);
            cdata_wr = d;
            cwr = wr;
            crd = rd;
            iaddr = AW'(ia);
            start = ($urandom_range(7, 0) == 0);
            tick();
            cwr = 1'b0;
            crd = 1'b0;
            start = 1'b0;
            $display("txn %0d kind %0d csel %0d addr %0d wr %0b rd %0b cdata_rd %h wr_count %0d err %0b",
                     n, kind, c, a, wr, rd, cdata_rd, wr_count, err);
            checks++;
            if (cdata_rd !== exp_rd) begin
                errors++;
                $display("FAIL rand_cdata_rd txn %0d: got %h want %h", n, cdata_rd, exp_rd);
            end
            checks++;
            if (wr_count !== 16'(exp_wr)) begin
                errors++;
                $display("FAIL rand_wr_count txn %0d: got %0d want %0d", n, wr_count, exp_wr);
            end
            checks++;
            if (err !== exp_err) begin
                errors++;
                $display("FAIL rand_err txn %0d: got %0b want %0b", n, err, exp_err);
            end
            checks++;
            if (idata !== exp_id || ready !== 1'b0) begin
                errors++;
                $display("FAIL rand_idata txn %0d: got idata=%h ready=%0b want %h and 0", n, idata, ready, exp_id);
            end
        end
        busy = 1'b0;
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL rand_done: got %0b want 1", done);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_preload_ready();
        test_layer_rw();
        test_bad_writes();
        test_reset_mid_run();
        test_load_outside_idle();
        test_timeout();
        test_run_limit();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
